// File: rtl/hififo_ctrl_regs.sv
// Control/status registers for the PCIe-to-FIFO bridge: PIO write decode,
// per-channel FIFO resets, interrupt status/mask and a read-completion FSM.
module hififo_ctrl_regs #(
    parameter int unsigned       NCHAN     = 8,
    parameter logic [NCHAN-1:0]  ENABLE    = '1,
    parameter logic [31:0]       BUILDTIME = 32'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [5:0]            wr_addr,
    input  logic [63:0]           wr_data,
    input  logic                  rr_valid,
    input  logic [7:0]            rr_addr,
    output logic                  rr_ready,
    output logic                  rc_valid,
    input  logic                  rc_ready,
    output logic [31:0]           rc_data,
    input  logic [32*NCHAN-1:0]   status,
    input  logic [NCHAN-1:0]      irq_in,
    output logic [NCHAN-1:0]      fifo_reset,
    output logic                  interrupt,
    input  logic                  interrupt_rdy
);
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RESP, S_ACK, S_HOLD} state_t;

    state_t            state, state_nx;
    logic [NCHAN-1:0]  fifo_rst_q, irq_status, irq_mask;
    logic [NCHAN-1:0]  wdata, fr_nx, mask_nx, w1c, cor, unmask;
    logic [4:0]        rd_idx;
    logic [31:0]       rd_val;
    logic              pend;
    logic              unused_bits;

    assign wdata       = wr_data[NCHAN-1:0];
    assign fifo_reset  = fifo_rst_q;
    assign unused_bits = ^{wr_data, rr_addr[7:6], rr_addr[0]};

    always_comb begin
        fr_nx   = fifo_rst_q;
        mask_nx = irq_mask;
        w1c     = '0;
        unmask  = '0;
        if (wr_valid) begin
            case (wr_addr)
                6'd3: fr_nx = fifo_rst_q | wdata;
                6'd4: fr_nx = fifo_rst_q & ~wdata;
                6'd5: begin
                    mask_nx = wdata;
                    unmask  = wdata & ~irq_mask & irq_status & ENABLE;
                end
                6'd6: w1c = wdata;
                default: ;
            endcase
        end
        // Disabled channels are held in reset regardless of writes.
        fr_nx = fr_nx | ~ENABLE;
    end

    assign pend = (|(irq_in & irq_mask & ENABLE)) | (|unmask);
    assign cor  = (state == S_LOOKUP && rd_idx == 5'd0) ? irq_status : '0;

    always_comb begin
        rd_val = '0;
        case (rd_idx)
            5'd0:       rd_val[NCHAN-1:0] = irq_status;
            5'd1:       rd_val[NCHAN-1:0] = ENABLE;
            5'd2:       rd_val = BUILDTIME;
            5'd3, 5'd4: rd_val[NCHAN-1:0] = fifo_rst_q;
            5'd5:       rd_val[NCHAN-1:0] = irq_mask & ENABLE;
            5'd6:       rd_val = 32'(NCHAN);
            default: ;
        endcase
        for (int unsigned i = 0; i < NCHAN; i++) begin
            if (rd_idx == 5'(16 + i) && ENABLE[i]) rd_val = status[32*i +: 32];
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (rr_valid) state_nx = S_LOOKUP;
            S_LOOKUP: state_nx = S_RESP;
            S_RESP:   if (rc_ready) state_nx = S_ACK;
            S_ACK:    state_nx = S_HOLD;
            S_HOLD:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            fifo_rst_q <= '1;
            irq_status <= '0;
            irq_mask   <= '1;
            interrupt  <= 1'b0;
            rc_valid   <= 1'b0;
            rc_data    <= '0;
            rr_ready   <= 1'b0;
            rd_idx     <= '0;
        end else begin
            state      <= state_nx;
            fifo_rst_q <= fr_nx;
            irq_mask   <= mask_nx;
            // New pulses override any clear landing in the same cycle.
            irq_status <= (irq_status & ~w1c & ~cor) | (irq_in & ENABLE);
            interrupt  <= interrupt ? ~interrupt_rdy : pend;
            rr_ready   <= (state == S_RESP) && rc_ready;
            if (state == S_IDLE && rr_valid) rd_idx <= rr_addr[5:1];
            if (state == S_LOOKUP) begin
                rc_data  <= rd_val;
                rc_valid <= 1'b1;
            end else if (state == S_RESP && rc_ready) begin
                rc_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hififo_ctrl_regs.sv
// Bench for hififo_ctrl_regs: directed register/interrupt scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_hififo_ctrl_regs;
    localparam int unsigned      NCHAN = 8;
    localparam logic [NCHAN-1:0] EN    = 8'h7F;
    localparam logic [31:0]      BT    = 32'h1234_5678;

    logic                 clock = 1'b0;
    logic                 reset, wr_valid, rr_valid, rr_ready, rc_valid, rc_ready;
    logic [5:0]           wr_addr;
    logic [63:0]          wr_data;
    logic [7:0]           rr_addr;
    logic [31:0]          rc_data;
    logic [32*NCHAN-1:0]  status;
    logic [NCHAN-1:0]     irq_in, fifo_reset;
    logic                 interrupt, interrupt_rdy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    bit          rnd_bg   = 1'b0;

    hififo_ctrl_regs #(.NCHAN(NCHAN), .ENABLE(EN), .BUILDTIME(BT)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rr_valid(rr_valid), .rr_addr(rr_addr), .rr_ready(rr_ready),
        .rc_valid(rc_valid), .rc_ready(rc_ready), .rc_data(rc_data),
        .status(status), .irq_in(irq_in), .fifo_reset(fifo_reset),
        .interrupt(interrupt), .interrupt_rdy(interrupt_rdy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: register contents and outputs as they stand after the last edge.
    logic [NCHAN-1:0] m_fr, m_mask, m_stat;
    logic             m_int, m_rcv, m_rrr;
    logic [31:0]      m_rcd;
    logic [4:0]       m_idx;
    bit               armed = 1'b0, busy = 1'b0;
    int unsigned      cyc = 0, lookup_cyc = 0, free_cyc = 0;

    function automatic logic [31:0] map_value(input logic [4:0] idx);
        logic [31:0] v;
        int k;
        v = '0;
        k = int'(idx) - 16;
        if (k >= 0) begin
            if (k < int'(NCHAN) && EN[k]) v = status[32*k +: 32];
        end else begin
            case (idx)
                5'd0:       v = 32'(m_stat);
                5'd1:       v = 32'(EN);
                5'd2:       v = BT;
                5'd3, 5'd4: v = 32'(m_fr);
                5'd5:       v = 32'(m_mask & EN);
                5'd6:       v = NCHAN;
                default:    v = '0;
            endcase
        end
        return v;
    endfunction

    always @(negedge clock) begin
        logic [NCHAN-1:0] n_fr, n_mask, clr, w;
        logic             n_int, n_rcv, n_rrr, pend;
        logic [31:0]      n_rcd;
        if (armed) begin
            chk("fifo_reset", 32'(fifo_reset), 32'(m_fr));
            chk("interrupt",  32'(interrupt),  32'(m_int));
            chk("rc_valid",   32'(rc_valid),   32'(m_rcv));
            chk("rr_ready",   32'(rr_ready),   32'(m_rrr));
            chk("rc_data",    rc_data,         m_rcd);
        end
        if (reset) begin
            m_fr = '1; m_mask = '1; m_stat = '0;
            m_int = 1'b0; m_rcv = 1'b0; m_rrr = 1'b0; m_rcd = '0;
            busy = 1'b0; armed = 1'b1;
        end else begin
            w      = wr_data[NCHAN-1:0];
            n_fr   = m_fr;
            n_mask = m_mask;
            clr    = '0;
            pend   = |(irq_in & m_mask & EN);
            if (wr_valid) begin
                case (wr_addr)
                    6'd3: n_fr = m_fr | w;
                    6'd4: n_fr = m_fr & ~w;
                    6'd5: begin
                        n_mask = w;
                        if (|(w & ~m_mask & m_stat & EN)) pend = 1'b1;
                    end
                    6'd6: clr = w;
                    default: ;
                endcase
            end
            n_fr  = n_fr | ~EN;
            n_rcv = m_rcv;
            n_rcd = m_rcd;
            n_rrr = 1'b0;
            if (busy && cyc >= free_cyc) busy = 1'b0;
            if (busy && cyc == lookup_cyc) begin
                n_rcd = map_value(m_idx);
                n_rcv = 1'b1;
                if (m_idx == 5'd0) clr = clr | m_stat;
            end else if (m_rcv && rc_ready) begin
                n_rcv    = 1'b0;
                n_rrr    = 1'b1;
                free_cyc = cyc + 3;
            end else if (!busy && rr_valid) begin
                busy       = 1'b1;
                m_idx      = rr_addr[5:1];
                lookup_cyc = cyc + 1;
                free_cyc   = 32'hFFFF_FFFF;
            end
            n_int  = m_int ? !interrupt_rdy : pend;
            m_stat = (m_stat & ~clr) | (irq_in & EN);
            m_fr = n_fr; m_mask = n_mask; m_int = n_int;
            m_rcv = n_rcv; m_rcd = n_rcd; m_rrr = n_rrr;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clock);
        #1;
        wr_valid      = 1'b0;
        irq_in        = '0;
        interrupt_rdy = 1'b0;
        if (rnd_bg) begin
            wr_valid      = ($urandom_range(0, 3) == 0);
            wr_addr       = 6'($urandom_range(0, 8));
            wr_data       = {$urandom, $urandom};
            irq_in        = ($urandom_range(0, 4) == 0) ? NCHAN'($urandom) : '0;
            interrupt_rdy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < int'(NCHAN); i++) status[32*i +: 32] = $urandom;
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [63:0] d, input logic [NCHAN-1:0] irq);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        irq_in   = irq;
        step();
    endtask

    task automatic irq_ack();
        interrupt_rdy = 1'b1;
        step();
    endtask

    task automatic do_read(input logic [4:0] idx, input int unsigned stall,
                           input logic [NCHAN-1:0] lk_irq, input bit has_exp,
                           input logic [31:0] exp);
        rr_addr  = {2'($urandom_range(0, 3)), idx, 1'($urandom_range(0, 1))};
        rr_valid = 1'b1;
        step();
        if (lk_irq != '0) irq_in = lk_irq;
        step();
        chk("read_latency", 32'(rc_valid), 32'd1);
        if (has_exp) chk("read_data", rc_data, exp);
        repeat (stall) step();
        if (has_exp && stall > 0) chk("read_data_stalled", rc_data, exp);
        rc_ready = 1'b1;
        step();
        rc_ready = 1'b0;
        chk("rr_ready_pulse", 32'(rr_ready), 32'd1);
        step();
        chk("rr_ready_single", 32'(rr_ready), 32'd0);
        step();
        rr_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r;
        logic [4:0]  ridx;
        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rr_valid = 1'b0; rr_addr = '0; rc_ready = 1'b0;
        irq_in = '0; interrupt_rdy = 1'b0;
        for (int i = 0; i < int'(NCHAN); i++) status[32*i +: 32] = 32'hA500_0000 + 32'(i);
        repeat (3) step();
        reset = 1'b0;
        chk("reset_fifo_reset", 32'(fifo_reset), 32'h0000_00FF);
        chk("reset_interrupt", 32'(interrupt), 32'd0);

        do_read(5'd3, 0, '0, 1'b1, 32'h0000_00FF);
        do_read(5'd1, 0, '0, 1'b1, 32'h0000_007F);
        do_read(5'd2, 0, '0, 1'b1, 32'h1234_5678);
        do_read(5'd5, 0, '0, 1'b1, 32'h0000_007F);
        do_read(5'd6, 0, '0, 1'b1, 32'h0000_0008);
        do_read(5'd7, 0, '0, 1'b1, 32'h0000_0000);
        do_read(5'd17, 0, '0, 1'b1, 32'hA500_0001);
        do_read(5'd23, 0, '0, 1'b1, 32'h0000_0000);
        do_read(5'd31, 0, '0, 1'b1, 32'h0000_0000);

        wr(6'd4, 64'h05, '0);
        do_read(5'd3, 0, '0, 1'b1, 32'h0000_00FA);
        wr(6'd3, 64'h01, '0);
        do_read(5'd4, 0, '0, 1'b1, 32'h0000_00FB);
        wr(6'd4, 64'h80, '0);
        do_read(5'd3, 0, '0, 1'b1, 32'h0000_00FB);
        wr(6'd7, 64'hFF, '0);
        do_read(5'd3, 0, '0, 1'b1, 32'h0000_00FB);

        irq_in = 8'h04;
        step();
        chk("irq_rise", 32'(interrupt), 32'd1);
        repeat (3) step();
        chk("irq_held", 32'(interrupt), 32'd1);
        irq_ack();
        chk("irq_fall", 32'(interrupt), 32'd0);
        do_read(5'd0, 0, '0, 1'b1, 32'h0000_0004);
        do_read(5'd0, 0, '0, 1'b1, 32'h0000_0000);

        wr(6'd5, 64'h00, '0);
        irq_in = 8'h02;
        step();
        step();
        chk("masked_no_irq", 32'(interrupt), 32'd0);
        wr(6'd5, 64'h02, '0);
        chk("unmask_irq", 32'(interrupt), 32'd1);
        irq_ack();
        do_read(5'd5, 0, '0, 1'b1, 32'h0000_0002);
        do_read(5'd0, 0, '0, 1'b1, 32'h0000_0002);
        wr(6'd5, 64'hFF, '0);

        wr(6'd6, 64'h08, 8'h08);
        irq_ack();
        do_read(5'd0, 0, '0, 1'b1, 32'h0000_0008);
        irq_in = 8'h08;
        step();
        do_read(5'd0, 0, 8'h08, 1'b1, 32'h0000_0008);
        do_read(5'd0, 0, '0, 1'b1, 32'h0000_0008);
        do_read(5'd0, 0, '0, 1'b1, 32'h0000_0000);
        irq_ack();

        do_read(5'd2, 10, '0, 1'b1, 32'h1234_5678);
        rr_addr  = 8'h02;
        rr_valid = 1'b1;
        repeat (5) step();
        reset    = 1'b1;
        rr_valid = 1'b0;
        step();
        reset = 1'b0;
        chk("reset_mid_read_rc_valid", 32'(rc_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_rr_ready_after_reset", 32'(rr_ready), 32'd0);
        end

        rnd_bg = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 3)) step();
            r = $urandom_range(0, 9);
            if (r < 3)      ridx = 5'd0;
            else if (r < 7) ridx = 5'($urandom_range(0, 7));
            else            ridx = 5'($urandom_range(16, 31));
            do_read(ridx, $urandom_range(0, 3), '0, 1'b0, '0);
        end
        rnd_bg = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hififo_ctrl_regs.md
Name: hififo_ctrl_regs

Overview:
- Parametrised control/status register block for the PCIe-to-FIFO bridge; serves PIO writes and PIO read requests from the RX path.
- Returns 32-bit read completions to the TX path; owns per-channel FIFO reset bits and interrupt status.
- Generalised to NCHAN channels; adds an interrupt mask, write-1-to-clear interrupt status, and an explicit read FSM with lossless clear-on-read.

Parameters:
- NCHAN, 8, number of FIFO channels (1..16).
- ENABLE, all ones, NCHAN-bit mask of instantiated channels.
- BUILDTIME, 32'd0, constant returned at read index 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  PIO write strobe
- wr_addr  in  6  PIO write qword index
- wr_data  in  64  PIO write data
- rr_valid  in  1  PIO read request pending
- rr_addr  in  8  PIO read byte-address bits; register index = rr_addr[5:1]
- rr_ready  out  1  one-cycle pulse: read request consumed
- rc_valid  out  1  completion data valid
- rc_ready  in  1  TX accepted completion
- rc_data  out  32  completion data
- status  in  32*NCHAN  per-channel status words, channel i at [32i+31:32i]
- irq_in  in  NCHAN  per-channel interrupt pulses
- fifo_reset  out  NCHAN  per-channel FIFO reset, level
- interrupt  out  1  interrupt request to core
- interrupt_rdy  in  1  core accepted interrupt

Behaviour:
- Reset values:
  - fifo_reset = all ones; irq_status = 0; irq_mask = all ones.
  - rc_valid = 0; rc_data = 0; rr_ready = 0; interrupt = 0; FSM = IDLE.
- Disabled channels (ENABLE bit 0):
  - fifo_reset bit permanently 1; irq_in bit ignored.
  - status reads 0; mask bit reads 0.
- Write map (on wr_valid; data[NCHAN-1:0] unless noted):
  - 3: fifo_reset |= data.
  - 4: fifo_reset &= ~data.
  - 5: irq_mask = data.
  - 6: irq_status &= ~data (W1C).
  - Other addresses: ignored, no side effect.
- irq_status:
  - Each cycle: irq_status |= irq_in & ENABLE.
  - A new pulse in the same cycle as a W1C or clear-on-read of that bit wins; the bit stays set.
- Interrupt request:
  - pend = |(irq_in & irq_mask & ENABLE), or a mask write newly unmasking a bit already set in irq_status.
  - interrupt rises the cycle after pend.
  - Held high until a cycle with interrupt_rdy = 1; falls the following cycle.
  - pend while high (including the rdy cycle) is merged; no second request is generated.
- Read map, index = rr_addr[5:1]:
  - 0: irq_status (clear-on-read).
  - 1: ENABLE.
  - 2: BUILDTIME.
  - 3 and 4: fifo_reset.
  - 5: irq_mask.
  - 6: NCHAN.
  - 16+i: status[i] for i < NCHAN.
  - All others: 0.
  - Values are zero-extended to 32 bits.
- Read FSM:
  - IDLE: on rr_valid, go to LOOKUP.
  - LOOKUP (1 cycle): rc_data latched from the map.
    - If index 0, the latched bits are cleared this cycle; bits set this cycle are kept.
    - Go to RESP.
  - RESP: rc_valid = 1, rc_data stable. On rc_ready, rc_valid falls the next cycle; go to ACK.
  - ACK (1 cycle): rr_ready = 1; go to HOLD.
  - HOLD (1 cycle): rr_valid ignored (upstream drops it here); go to IDLE.
  - Latency: rr_valid in IDLE at cycle n gives rc_valid = 1 at cycle n+2.
  - Minimum request spacing: 5 cycles.
- Reset mid-read: FSM returns to IDLE immediately; rc_valid and rr_ready go 0; no completion is issued.
- Writes are accepted in any FSM state. A write in the LOOKUP cycle is visible only to later reads.

Test Plan:
- After reset, read idx 3 -> rc_data = 0x000000FF at +2 cycles; rr_ready pulses once after rc_ready.
- Write 0x05 to addr 4, then read idx 3 -> 0xFA. Write 0x01 to addr 3 -> read 0xFB. With ENABLE = 8'h7F, bit 7 stays 1 after writing 0x80 to addr 4.
- irq_in[2] pulse -> interrupt = 1 next cycle, held until interrupt_rdy; read idx 0 -> 0x04; second read idx 0 -> 0x00.
- Mask = 0x00, pulse irq_in[1] -> interrupt stays 0 and irq_status = 0x02; write mask 0x02 -> interrupt rises next cycle.
- irq_in[3] pulse in the same cycle as W1C 0x08 (addr 6), and separately in the LOOKUP cycle of an idx-0 read -> bit 3 remains set in both cases.
- Hold rc_ready = 0 for 10 cycles -> rc_valid and rc_data stable; assert reset in RESP -> rc_valid = 0 next cycle, no rr_ready pulse.
